sha256_msg_padder: RTL

- Front end for the SHA-256 core. Takes a byte message as a stream of big-endian 32-bit words and emits FIPS 180-4 padded 512-bit chunks.
- Padding is a single 0x80 byte, then zero fill, then the 64-bit message bit length.
- Each chunk leaves on a valid/ready handshake, flagged first/last. The mining controller loads each chunk into the hash core's chunk input.

---
 rtl/sha256_msg_padder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
// Front end for the SHA-256 core. Packs a byte message, delivered as
// big-endian 32-bit words, into FIPS 180-4 padded 512-bit chunks. The
// padding is a 0x80 byte, zero fill, and the 64-bit message bit length.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-low reset
//   in_valid     input word valid
//   in_ready     word accepted this cycle (only while filling a chunk)
//   in_data      message word, in_data[31:24] is the earliest byte
//   in_last      this word ends the message
//   in_nbytes    valid bytes (left-justified) in the last word, 0..4
//   chunk_valid  padded chunk available
//   chunk_ready  consumer takes the chunk
//   chunk        512-bit chunk, chunk[511:504] is byte 0
//   chunk_first  first chunk of a message
//   chunk_last   final chunk of a message (carries the length)
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic         chunk_valid,
  input  logic         chunk_ready,
  output logic [511:0] chunk,
  output logic         chunk_first,
  output logic         chunk_last
);

  typedef enum logic [1:0] {S_FILL, S_OUT, S_EXTRA} state_t;

  state_t           state, state_next;
  logic [3:0]       widx, widx_next;
  logic [LEN_W-1:0] count, count_next, count_sum;
  logic             seen, seen_next;
  logic             extra_pending, extra_pending_next;
  logic             extra_pad80, extra_pad80_next;
  logic             run;
  logic [511:0]     chunk_next;
  logic             chunk_valid_next, chunk_first_next, chunk_last_next;
  logic [2:0]       nb;
  logic [31:0]      word_masked;
  logic [6:0]       b_used;
  logic [63:0]      len_fill, len_done;
  logic             accept;

  // run holds in_ready low during reset and releases it once reset is gone
  assign in_ready  = run && (state == S_FILL);
  assign accept    = in_valid && in_ready;
  assign count_sum = count + LEN_W'(nb);
  assign len_fill  = 64'(count_sum) << 3;
  assign len_done  = 64'(count) << 3;

  // Effective byte count of the incoming word, with unused trailing bytes
  // zeroed, and the number of chunk bytes used once this word lands.
  always_comb begin
    nb = 3'd4;
    if (in_last && (in_nbytes < 3'd4)) nb = in_nbytes;
    word_masked = in_data;
    for (int k = 0; k < 4; k++) begin
      if (k >= int'(nb)) word_masked[31-8*k -: 8] = 8'h00;
    end
    b_used = {1'b0, widx, 2'b00} + {4'b0000, nb};
  end

  // Next-state and datapath: fill words, pad on the last word, then hold
  // the chunk until it is taken; a length-only chunk follows if needed.
  always_comb begin
    state_next         = state;
    widx_next          = widx;
    count_next         = count;
    seen_next          = seen;
    extra_pending_next = extra_pending;
    extra_pad80_next   = extra_pad80;
    chunk_next         = chunk;
    chunk_valid_next   = chunk_valid;
    chunk_first_next   = chunk_first;
    chunk_last_next    = chunk_last;
    case (state)
      S_FILL: begin
        if (accept) begin
          count_next = count_sum;
          for (int w = 0; w < 16; w++) begin
            if (w == int'(widx)) chunk_next[511-32*w -: 32] = word_masked;
          end
          if (!in_last) begin
            widx_next = widx + 4'd1;
            if (widx == 4'd15) begin
              state_next         = S_OUT;
              chunk_valid_next   = 1'b1;
              chunk_first_next   = !seen;
              chunk_last_next    = 1'b0;
              extra_pending_next = 1'b0;
            end
          end else begin
            widx_next        = 4'd0;
            state_next       = S_OUT;
            chunk_valid_next = 1'b1;
            chunk_first_next = !seen;
            // Stale bytes from an earlier chunk beyond the data are cleared
            for (int i = 0; i < 64; i++) begin
              if (i == int'(b_used))     chunk_next[511-8*i -: 8] = 8'h80;
              else if (i > int'(b_used)) chunk_next[511-8*i -: 8] = 8'h00;
            end
            if (b_used <= 7'd55) begin
              chunk_next[63:0]   = len_fill;
              chunk_last_next    = 1'b1;
              extra_pending_next = 1'b0;
              extra_pad80_next   = 1'b0;
            end else begin
              // No room for the length; a full data chunk also lacks the 0x80
              chunk_last_next    = 1'b0;
              extra_pending_next = 1'b1;
              extra_pad80_next   = (b_used == 7'd64);
            end
          end
        end
      end
      S_OUT: begin
        if (chunk_ready) begin
          chunk_valid_next = 1'b0;
          if (extra_pending) begin
            state_next = S_EXTRA;
            seen_next  = 1'b1;
          end else if (chunk_last) begin
            state_next = S_FILL;
            count_next = '0;
            seen_next  = 1'b0;
          end else begin
            state_next = S_FILL;
            seen_next  = 1'b1;
          end
        end
      end
      S_EXTRA: begin
        chunk_next           = '0;
        chunk_next[511:504]  = extra_pad80 ? 8'h80 : 8'h00;
        chunk_next[63:0]     = len_done;
        chunk_valid_next     = 1'b1;
        chunk_first_next     = !seen;
        chunk_last_next      = 1'b1;
        extra_pending_next   = 1'b0;
        state_next           = S_OUT;
      end
      default: state_next = S_FILL;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= S_FILL;
      widx          <= 4'd0;
      count         <= '0;
      seen          <= 1'b0;
      extra_pending <= 1'b0;
      extra_pad80   <= 1'b0;
      run           <= 1'b0;
      chunk         <= '0;
      chunk_valid   <= 1'b0;
      chunk_first   <= 1'b0;
      chunk_last    <= 1'b0;
    end else begin
      state         <= state_next;
      widx          <= widx_next;
      count         <= count_next;
      seen          <= seen_next;
      extra_pending <= extra_pending_next;
      extra_pad80   <= extra_pad80_next;
      run           <= 1'b1;
      chunk         <= chunk_next;
      chunk_valid   <= chunk_valid_next;
      chunk_first   <= chunk_first_next;
      chunk_last    <= chunk_last_next;
    end
  end

endmodule
